latch_reg_serializer: RTL and testbench
=======================================

# latch_reg_serializer

Downstream consumer of the latch register. On each frame request it snapshots the WIDTH-bit latched sensor vector and pulses a clear back to the latch register so new events start accumulating. It then shifts the snapshot out LSB-first, followed by an even-parity bit, over a valid/ready serial handshake toward the satellite link transmitter.

## Interface
- WIDTH, 32, number of latched bits per frame (≥2)
- masterClk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- latchOutput  in  WIDTH  latched vector from the latch register
- frameStart  in  1  single-cycle frame request
- latchClear  out  1  one-cycle pulse; drives the latch register's reset
- serialData  out  1  current bit (snapshot bit or parity)
- serialValid  out  1  serialData is valid
- serialReady  in  1  downstream accepts serialData this cycle
- busy  out  1  frame in progress
- frameDone  out  1  one-cycle pulse after the parity bit is accepted
- overrun  out  1  sticky: frameStart arrived while busy

## Operation
- Reset values: all outputs 0; snapshot 0; bit counter 0; state IDLE.
- States:
  - IDLE: busy=0, serialValid=0. If frameStart=1:
    - snapshot <= latchOutput.
    - bitCnt <= 0.
    - latchClear <= 1 for the next cycle only.
    - state <= SHIFT.
  - SHIFT: busy=1, serialValid=1, serialData=snapshot[bitCnt].
    - Transfer occurs when serialValid && serialReady at the clock edge.
    - On transfer, bitCnt increments. After the transfer of bit WIDTH-1, state <= PARITY.
  - PARITY: busy=1, serialValid=1, serialData=^snapshot, so the total count of ones including parity is even.
    - On transfer: state <= IDLE and frameDone=1 for the next cycle.
- Handshake:
  - serialData is stable while serialValid=1 and serialReady=0.
  - serialValid never drops before a transfer.
  - serialReady is ignored while serialValid=0.
- The snapshot is frozen for the whole frame. Changes on latchOutput after capture do not affect the frame.
- frameStart while busy=1:
  - The request is ignored.
  - overrun <= 1 and stays 1 until reset.
  - The frame in progress is unaffected.
- frameStart in the frameDone cycle is legal, because that cycle is IDLE, and is accepted normally.
- The latch register's clear and new events interact as follows:
  - A bit whose input is still high after the clear re-latches in the latch register.
  - The block does not compensate for this.
- bitCnt width is clog2(WIDTH). It does not wrap within a frame.
- Reset mid-frame:
  - The next cycle is IDLE with all outputs 0 and overrun cleared.
  - The partial frame is discarded. No frameDone is issued and no latchClear is issued.

## Timing
- frameStart sampled high in IDLE at cycle T:
  - latchClear=1, busy=1, serialValid=1 and serialData=latchOutput[0] (as sampled at T) all in cycle T+1.
- With serialReady held 1:
  - Bit k is presented in cycle T+1+k (k=0..WIDTH-1).
  - Parity is presented in cycle T+1+WIDTH.
  - frameDone=1 and busy=0 in cycle T+2+WIDTH.
- Minimum frame period is WIDTH+2 cycles (WIDTH=32: 34).
- All outputs are registered. There is no combinational path from any input to any output.

## Test plan
- Reset for 2 cycles with arbitrary inputs -> all outputs 0. No latchClear pulse while reset=1.
- latchOutput=32'h0000_0005, frameStart at T, serialReady=1 -> the following must hold:
  - latchClear=1 only in T+1.
  - Bits observed are 1,0,1 then 29 zeros.
  - Parity is 0 at T+33.
  - frameDone at T+34.
  - busy is high for T+1..T+33.
- latchOutput=32'h8000_0001, serialReady alternating 0/1 every cycle -> the following must hold:
  - serialData/serialValid stay stable through every ready-low cycle.
  - The sequence is 1, 30 zeros, 1, then parity 0.
  - Exactly 33 transfers occur.
- During a frame, latchOutput changes to 32'hFFFF_FFFF and a second frameStart pulses -> the following must hold:
  - Output bits still match the original snapshot.
  - overrun=1 from the next cycle onward.
  - No extra frame is produced.
- latchOutput=32'h0000_0007 -> parity bit 1. A frameStart asserted in the frameDone cycle starts a new frame with latchClear in the next cycle.
- Reset asserted after 10 transfers -> the following must hold:
  - The next cycle has serialValid=0, busy=0, overrun=0.
  - No frameDone is produced.
  - A subsequent frameStart restarts output from bit 0.

Source files
------------

// File: rtl/latch_reg_serializer.sv
// latch_reg_serializer
// Snapshots the latched sensor vector on a frame request, pulses a clear back
// to the latch register, then streams the snapshot LSB-first followed by an
// even-parity bit over a valid/ready serial link.
//
// Handshake: a bit moves when serialValid and serialReady are both high at a
// rising edge of masterClk. While serialValid is high and serialReady is low,
// serialData and serialValid hold their values. serialValid only drops after
// the parity bit transfers. serialReady is ignored while serialValid is low.
module latch_reg_serializer #(
  parameter int WIDTH = 32
) (
  input  logic             masterClk,
  input  logic             reset,
  input  logic [WIDTH-1:0] latchOutput,
  input  logic             frameStart,
  output logic             latchClear,
  output logic             serialData,
  output logic             serialValid,
  input  logic             serialReady,
  output logic             busy,
  output logic             frameDone,
  output logic             overrun,
  output logic [1:0]       fsm_state
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

  state_t          state_q;
  logic [WIDTH-1:0] snapshot;
  logic [CW-1:0]    bit_cnt;
  logic [CW-1:0]    next_cnt;
  logic             xfer;

  assign xfer      = serialValid & serialReady;
  assign next_cnt  = bit_cnt + 1'b1;
  assign fsm_state = state_q;

  // Frame sequencer: capture, clear pulse, bit shifting, parity and flags.
  always_ff @(posedge masterClk) begin
    if (reset) begin
      state_q     <= IDLE;
      snapshot    <= '0;
      bit_cnt     <= '0;
      latchClear  <= 1'b0;
      serialData  <= 1'b0;
      serialValid <= 1'b0;
      busy        <= 1'b0;
      frameDone   <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      latchClear <= 1'b0;
      frameDone  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (frameStart) begin
            snapshot    <= latchOutput;
            bit_cnt     <= '0;
            latchClear  <= 1'b1;
            busy        <= 1'b1;
            serialValid <= 1'b1;
            serialData  <= latchOutput[0];
            state_q     <= SHIFT;
          end
        end
        SHIFT: begin
          if (frameStart) overrun <= 1'b1;
          if (xfer) begin
            if (bit_cnt == LAST) begin
              // Counter stays at the last index; parity goes out next.
              serialData <= ^snapshot;
              state_q    <= PARITY;
            end else begin
              bit_cnt    <= next_cnt;
              serialData <= snapshot[next_cnt];
            end
          end
        end
        PARITY: begin
          if (frameStart) overrun <= 1'b1;
          if (xfer) begin
            serialValid <= 1'b0;
            serialData  <= 1'b0;
            busy        <= 1'b0;
            frameDone   <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          serialValid <= 1'b0;
          serialData  <= 1'b0;
          busy        <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_latch_reg_serializer.sv
// Directed bench for latch_reg_serializer (WIDTH=32).
module tb_latch_reg_serializer;

  logic        masterClk;
  logic        reset;
  logic [31:0] latchOutput;
  logic        frameStart;
  logic        latchClear;
  logic        serialData;
  logic        serialValid;
  logic        serialReady;
  logic        busy;
  logic        frameDone;
  logic        overrun;
  logic [1:0]  fsm_state;

  int checks = 0;
  int failures = 0;

  latch_reg_serializer #(.WIDTH(32)) dut (
    .masterClk   (masterClk),
    .reset       (reset),
    .latchOutput (latchOutput),
    .frameStart  (frameStart),
    .latchClear  (latchClear),
    .serialData  (serialData),
    .serialValid (serialValid),
    .serialReady (serialReady),
    .busy        (busy),
    .frameDone   (frameDone),
    .overrun     (overrun),
    .fsm_state   (fsm_state)
  );

  // Clock
  initial masterClk = 1'b0;
  always #5 masterClk = ~masterClk;

  // Advance one cycle; outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge masterClk);
    #1;
  endtask

  task automatic test_reset();
    reset       = 1'b1;
    frameStart  = 1'b1;
    serialReady = 1'b1;
    for (int i = 0; i < 2; i++) begin
      latchOutput = $urandom;
      tick();
      checks++;
      if ({latchClear, serialData, serialValid, busy, frameDone, overrun} !== 6'b0) begin
        failures++;
        $display("FAIL reset_outputs cycle %0d: got lc=%b d=%b v=%b busy=%b fd=%b ov=%b, want all 0",
                 i, latchClear, serialData, serialValid, busy, frameDone, overrun);
      end
      checks++;
      if (fsm_state !== 2'd0) begin
        failures++;
        $display("FAIL reset_state: got %0d want 0", fsm_state);
      end
    end
    frameStart  = 1'b0;
    latchOutput = '0;
    reset       = 1'b0;
    tick();
  endtask

  // pat 0x5, ready held high: bits 1,0,1, 29 zeros, parity 0, done at T+34.
  task automatic test_basic();
    logic [31:0] pat;
    logic        exp_d;
    pat         = 32'h0000_0005;
    latchOutput = pat;
    serialReady = 1'b1;
    frameStart  = 1'b1;
    tick();
    frameStart  = 1'b0;
    latchOutput = 32'hFFFF_FFFF;
    for (int i = 0; i < 35; i++) begin
      exp_d = (i < 32) ? pat[i] : 1'b0;
      checks++;
      if (latchClear !== (i == 0)) begin
        failures++;
        $display("FAIL basic_clear i=%0d: got %b want %b", i, latchClear, (i == 0));
      end
      checks++;
      if (busy !== (i <= 32) || serialValid !== (i <= 32)) begin
        failures++;
        $display("FAIL basic_busy_valid i=%0d: got busy=%b v=%b want %b", i, busy, serialValid, (i <= 32));
      end
      checks++;
      if (serialData !== exp_d) begin
        failures++;
        $display("FAIL basic_data i=%0d: got %b want %b", i, serialData, exp_d);
      end
      checks++;
      if (frameDone !== (i == 33)) begin
        failures++;
        $display("FAIL basic_done i=%0d: got %b want %b", i, frameDone, (i == 33));
      end
      tick();
    end
    latchOutput = '0;
  endtask

  // pat 0x8000_0001 with ready toggling: holds stable, 33 transfers.
  task automatic test_alternate();
    logic [31:0] pat;
    logic [0:0]  exp_q[$];
    logic [0:0]  e;
    int          xfers;
    logic        done, prev_v, prev_x, prev_d;
    pat = 32'h8000_0001;
    exp_q.delete();
    for (int k = 0; k < 32; k++) exp_q.push_back(pat[k]);
    exp_q.push_back(1'b0);
    latchOutput = pat;
    serialReady = 1'b0;
    frameStart  = 1'b1;
    tick();
    frameStart  = 1'b0;
    latchOutput = 32'hFFFF_FFFF;
    xfers  = 0;
    done   = 1'b0;
    prev_v = 1'b0;
    prev_x = 1'b0;
    prev_d = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      serialReady = i[0];
      if (prev_v && !prev_x) begin
        checks++;
        if (serialValid !== 1'b1 || serialData !== prev_d) begin
          failures++;
          $display("FAIL alt_hold i=%0d: got v=%b d=%b want v=1 d=%b", i, serialValid, serialData, prev_d);
        end
      end
      if (frameDone === 1'b1) begin
        done = 1'b1;
      end else if (serialValid === 1'b1 && serialReady === 1'b1) begin
        xfers++;
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          checks++;
          if (serialData !== e) begin
            failures++;
            $display("FAIL alt_data xfer=%0d: got %b want %b", xfers, serialData, e);
          end
        end
      end
      prev_v = serialValid;
      prev_x = serialValid & serialReady;
      prev_d = serialData;
      tick();
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL alt_timeout: got no frameDone in 200 cycles, want frameDone");
    end
    checks++;
    if (xfers != 33 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL alt_count: got %0d transfers (%0d left), want 33", xfers, exp_q.size());
    end
    serialReady = 1'b1;
    latchOutput = '0;
  endtask

  // pat 0x7 gives parity 1; frameStart in the frameDone cycle starts 0x2.
  task automatic test_back_to_back();
    logic [31:0] pat, pat2;
    logic        exp_d;
    pat  = 32'h0000_0007;
    pat2 = 32'h0000_0002;
    latchOutput = pat;
    serialReady = 1'b1;
    frameStart  = 1'b1;
    tick();
    frameStart  = 1'b0;
    for (int i = 0; i < 34; i++) begin
      exp_d = (i < 32) ? pat[i] : (i == 32);
      checks++;
      if (serialData !== exp_d) begin
        failures++;
        $display("FAIL b2b_first_data i=%0d: got %b want %b", i, serialData, exp_d);
      end
      checks++;
      if (frameDone !== (i == 33)) begin
        failures++;
        $display("FAIL b2b_first_done i=%0d: got %b want %b", i, frameDone, (i == 33));
      end
      if (i == 33) begin
        frameStart  = 1'b1;
        latchOutput = pat2;
      end
      tick();
    end
    frameStart  = 1'b0;
    latchOutput = '0;
    for (int j = 0; j < 34; j++) begin
      exp_d = (j < 32) ? pat2[j] : (j == 32);
      checks++;
      if (latchClear !== (j == 0)) begin
        failures++;
        $display("FAIL b2b_clear j=%0d: got %b want %b", j, latchClear, (j == 0));
      end
      checks++;
      if (busy !== (j <= 32)) begin
        failures++;
        $display("FAIL b2b_busy j=%0d: got %b want %b", j, busy, (j <= 32));
      end
      checks++;
      if (serialData !== exp_d) begin
        failures++;
        $display("FAIL b2b_second_data j=%0d: got %b want %b", j, serialData, exp_d);
      end
      checks++;
      if (frameDone !== (j == 33)) begin
        failures++;
        $display("FAIL b2b_second_done j=%0d: got %b want %b", j, frameDone, (j == 33));
      end
      tick();
    end
    checks++;
    if (overrun !== 1'b0) begin
      failures++;
      $display("FAIL b2b_overrun: got %b want 0", overrun);
    end
  endtask

  // pat 0x1234 (parity 1); mid-frame data change and second request.
  task automatic test_overrun();
    logic [31:0] pat;
    logic        exp_d;
    pat         = 32'h0000_1234;
    latchOutput = pat;
    serialReady = 1'b1;
    frameStart  = 1'b1;
    tick();
    frameStart  = 1'b0;
    for (int i = 0; i < 34; i++) begin
      if (i == 3) begin
        frameStart  = 1'b1;
        latchOutput = 32'hFFFF_FFFF;
      end else begin
        frameStart  = 1'b0;
      end
      exp_d = (i < 32) ? pat[i] : (i == 32);
      checks++;
      if (serialData !== exp_d) begin
        failures++;
        $display("FAIL ovr_data i=%0d: got %b want %b", i, serialData, exp_d);
      end
      checks++;
      if (overrun !== (i >= 4)) begin
        failures++;
        $display("FAIL ovr_flag i=%0d: got %b want %b", i, overrun, (i >= 4));
      end
      checks++;
      if (frameDone !== (i == 33)) begin
        failures++;
        $display("FAIL ovr_done i=%0d: got %b want %b", i, frameDone, (i == 33));
      end
      tick();
    end
    frameStart = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (busy !== 1'b0 || serialValid !== 1'b0 || frameDone !== 1'b0 || overrun !== 1'b1) begin
        failures++;
        $display("FAIL ovr_no_extra i=%0d: got busy=%b v=%b fd=%b ov=%b want 0,0,0,1",
                 i, busy, serialValid, frameDone, overrun);
      end
      tick();
    end
    latchOutput = '0;
  endtask

  // Reset after 10 transfers discards the frame; next frame starts at bit 0.
  task automatic test_reset_mid();
    logic [31:0] pat, pat2;
    logic        exp_d;
    pat  = 32'h0000_0F0F;
    pat2 = 32'h0000_0003;
    latchOutput = pat;
    serialReady = 1'b1;
    frameStart  = 1'b1;
    tick();
    frameStart  = 1'b0;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (serialData !== pat[i]) begin
        failures++;
        $display("FAIL rst_mid_data i=%0d: got %b want %b", i, serialData, pat[i]);
      end
      tick();
    end
    checks++;
    if (overrun !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_pre: got ov=%b busy=%b want 1,1", overrun, busy);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if ({latchClear, serialData, serialValid, busy, frameDone, overrun} !== 6'b0) begin
      failures++;
      $display("FAIL rst_mid_outputs: got lc=%b d=%b v=%b busy=%b fd=%b ov=%b want all 0",
               latchClear, serialData, serialValid, busy, frameDone, overrun);
    end
    tick();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (frameDone !== 1'b0 || busy !== 1'b0 || latchClear !== 1'b0) begin
        failures++;
        $display("FAIL rst_mid_quiet i=%0d: got fd=%b busy=%b lc=%b want 0", i, frameDone, busy, latchClear);
      end
      tick();
    end
    latchOutput = pat2;
    frameStart  = 1'b1;
    tick();
    frameStart  = 1'b0;
    for (int j = 0; j < 34; j++) begin
      exp_d = (j < 32) ? pat2[j] : 1'b0;
      checks++;
      if (latchClear !== (j == 0)) begin
        failures++;
        $display("FAIL rst_restart_clear j=%0d: got %b want %b", j, latchClear, (j == 0));
      end
      checks++;
      if (serialData !== exp_d) begin
        failures++;
        $display("FAIL rst_restart_data j=%0d: got %b want %b", j, serialData, exp_d);
      end
      checks++;
      if (frameDone !== (j == 33)) begin
        failures++;
        $display("FAIL rst_restart_done j=%0d: got %b want %b", j, frameDone, (j == 33));
      end
      tick();
    end
  endtask

  initial begin
    reset       = 1'b1;
    latchOutput = '0;
    frameStart  = 1'b0;
    serialReady = 1'b0;
    test_reset();
    test_basic();
    test_alternate();
    test_back_to_back();
    test_overrun();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
